// File: rtl/pulse_watchdog.sv
// Pulse/heartbeat watchdog: measures cycles from arm (then between rising edges) and flags a sticky timeout.
// Define PULSE_WATCHDOG_EARLY_EN to add the "interval shorter than MIN_INTERVAL" strobe on early.
module pulse_watchdog #(
    parameter int BUS_WIDTH    = 12,
    parameter int TIMEOUT      = 1000,
    parameter int MIN_INTERVAL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 pulse_in,
    output logic [BUS_WIDTH-1:0] interval,
    output logic                 interval_valid,
    output logic                 timeout,
    output logic                 early,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam logic [BUS_WIDTH-1:0] CNT_LAST = BUS_WIDTH'(TIMEOUT - 1);

    // The counter must be able to hold TIMEOUT itself, since an edge on the last cycle reports it.
    if (TIMEOUT < 2 || TIMEOUT > (2 ** BUS_WIDTH) - 1 || MIN_INTERVAL < 1) begin : g_param_check
        $error("pulse_watchdog: illegal parameter combination");
    end

    logic [1:0]           state;
    logic [BUS_WIDTH-1:0] cnt;
    logic [BUS_WIDTH-1:0] cnt_inc;
    logic                 pulse_q;
    logic                 pulse_edge;

    assign cnt_inc    = cnt + 1'b1;
    assign pulse_edge = pulse_in & ~pulse_q;
    assign busy       = (state == ST_WAIT);

    // Dropping arm abandons everything except the last reported interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            pulse_q        <= 1'b0;
            interval       <= '0;
            interval_valid <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            pulse_q        <= pulse_in;
            interval_valid <= 1'b0;
            if (!arm) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_WAIT;
                        cnt     <= '0;
                        timeout <= 1'b0;
                    end
                    ST_WAIT: begin
                        // An edge on the final counted cycle wins over the timeout.
                        if (pulse_edge) begin
                            interval       <= cnt_inc;
                            interval_valid <= 1'b1;
                            cnt            <= '0;
                        end else if (cnt == CNT_LAST) begin
                            timeout <= 1'b1;
                            state   <= ST_TIMEOUT;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_TIMEOUT: begin
                        state <= ST_TIMEOUT;
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PULSE_WATCHDOG_EARLY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            early <= 1'b0;
        end else begin
            early <= arm && (state == ST_WAIT) && pulse_edge
                     && (int'(cnt_inc) < MIN_INTERVAL);
        end
    end
`else
    assign early = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_watchdog.sv
// Randomized scoreboard bench for pulse_watchdog; reference model tracks elapsed cycles since arm/last edge.
// Early-strobe checks follow PULSE_WATCHDOG_EARLY_EN.
module tb_pulse_watchdog;

    localparam int BW  = 8;
    localparam int TMO = 10;
    localparam int MIN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          pulse_in = 1'b0;
    logic [BW-1:0] interval;
    logic          interval_valid;
    logic          timeout;
    logic          early;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef enum {M_IDLE, M_WATCH, M_EXPIRED} mode_t;
    typedef struct {
        int cycle;
        int interval;
        bit early;
    } exp_t;

    exp_t  sb[$];
    mode_t m_mode       = M_IDLE;
    int    m_ref        = 0;
    bit    m_prev       = 1'b0;
    int    exp_interval = 0;
    bit    exp_timeout  = 1'b0;

    pulse_watchdog #(.BUS_WIDTH(BW), .TIMEOUT(TMO), .MIN_INTERVAL(MIN)) dut (
        .clk(clk), .rst(rst), .arm(arm), .pulse_in(pulse_in),
        .interval(interval), .interval_valid(interval_valid),
        .timeout(timeout), .early(early), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: elapsed time is simply (posedge number - reference posedge).
    task automatic model_step(input int n, input logic r, input logic a, input logic p);
        bit   rise;
        int   elapsed;
        exp_t e;
        if (r) begin
            m_mode = M_IDLE; m_prev = 1'b0; exp_interval = 0; exp_timeout = 1'b0;
            return;
        end
        rise   = p && !m_prev;
        m_prev = p;
        if (!a) begin
            m_mode = M_IDLE; exp_timeout = 1'b0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_WATCH; m_ref = n; exp_timeout = 1'b0;
        end else if (m_mode == M_WATCH) begin
            elapsed = n - m_ref;
            if (rise) begin
                e.cycle = n; e.interval = elapsed; e.early = (elapsed < MIN);
                sb.push_back(e);
                exp_interval = elapsed;
                m_ref = n;
            end else if (elapsed >= TMO) begin
                m_mode = M_EXPIRED; exp_timeout = 1'b1;
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic a, input logic p);
        @(negedge clk);
        rst = r; arm = a; pulse_in = p;
        model_step(cyc + 1, r, a, p);
    endtask

    task automatic run(input logic a, input logic p, input int n);
        repeat (n) apply_stimulus(1'b0, a, p);
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Monitor: samples 1 time unit after each posedge, pops the scoreboard on every strobe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check_output("busy", int'(busy), int'(m_mode == M_WATCH));
            check_output("timeout", int'(timeout), int'(exp_timeout));
            check_output("interval", int'(interval), exp_interval);
            if (interval_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("strobe_cycle", cyc, e.cycle);
                    check_output("strobe_interval", int'(interval), e.interval);
`ifdef PULSE_WATCHDOG_EARLY_EN
                    check_output("early", int'(early), int'(e.early));
`endif
                end
            end else begin
                check_output("valid_low", int'(interval_valid), 0);
                if (sb.size() > 0 && sb[0].cycle <= cyc) begin
                    e = sb.pop_front();
                    check_output("missed_strobe_at", cyc, e.cycle - 1);
                end
`ifdef PULSE_WATCHDOG_EARLY_EN
                check_output("early_idle", int'(early), 0);
`endif
            end
`ifndef PULSE_WATCHDOG_EARLY_EN
            check_output("early_off", int'(early), 0);
`endif
        end
    end

    initial begin
        int  toggle_pct;
        logic p;
        // Reset, then arm with a quiet line until timeout.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        run(1'b1, 1'b0, 13);
        // Single measurement: edge sampled at E6.
        run(1'b0, 1'b0, 1); run(1'b1, 1'b0, 1); run(1'b1, 1'b0, 5); run(1'b1, 1'b1, 2); run(1'b1, 1'b0, 3);
        // Heartbeat of period 7.
        run(1'b0, 1'b0, 1); run(1'b1, 1'b0, 1);
        repeat (5) begin run(1'b1, 1'b0, 6); run(1'b1, 1'b1, 1); end
        // Boundary: edge at E10 is in time; edge at E11 is after timeout.
        run(1'b0, 1'b0, 1); run(1'b1, 1'b0, 1); run(1'b1, 1'b0, 9); run(1'b1, 1'b1, 1); run(1'b1, 1'b0, 2);
        run(1'b0, 1'b0, 1); run(1'b1, 1'b0, 1); run(1'b1, 1'b0, 10); run(1'b1, 1'b1, 1); run(1'b1, 1'b0, 2);
        // Rearm after timeout, then reset mid-count.
        run(1'b0, 1'b0, 1); run(1'b1, 1'b0, 3);
        run(1'b0, 1'b0, 1); run(1'b1, 1'b0, 1); run(1'b1, 1'b0, 5);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        run(1'b1, 1'b0, 2);
        // Edges 3 cycles apart.
        run(1'b0, 1'b0, 1); run(1'b1, 1'b0, 1);
        repeat (4) begin run(1'b1, 1'b0, 2); run(1'b1, 1'b1, 1); end
        // Randomized traffic with varying pulse density.
        p = 1'b0;
        toggle_pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) toggle_pct = $urandom_range(3, 60);
            if ($urandom_range(0, 99) < toggle_pct) p = ~p;
            apply_stimulus($urandom_range(0, 299) == 0,
                           $urandom_range(0, 59) != 0, p);
        end
        run(1'b0, 1'b0, 3);
        check_output("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_watchdog.md
Name: pulse_watchdog

Overview:
Receiving-end companion to the one-shot terminal-count counter. It watches a pulse or strobe line (for example another block's cout) and measures the interval in clk cycles between arming and the first rising edge, then between successive rising edges. If no edge arrives within TIMEOUT cycles, it raises a sticky timeout flag. Used for power-on sequencing checks and heartbeat supervision.

Parameters:
- BUS_WIDTH, 12: width of the interval counter and output. Must satisfy TIMEOUT <= 2^BUS_WIDTH - 1.
- TIMEOUT, 1000: maximum allowed interval in cycles. Must be >= 2.
- MIN_INTERVAL, 4: minimum allowed interval in cycles. Used only with PULSE_WATCHDOG_EARLY_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  level enable. High = monitor; low = return to IDLE.
- pulse_in  in  1  monitored line, synchronous to clk. Rising edge detected internally.
- interval  out  BUS_WIDTH  last measured interval, 1..TIMEOUT cycles.
- interval_valid  out  1  one-cycle strobe: interval updated.
- timeout  out  1  sticky: no edge within TIMEOUT cycles.
- early  out  1  one-cycle strobe: measured interval < MIN_INTERVAL.
- busy  out  1  high in WAIT state.

Behaviour:
- Reset (rst high at posedge): state=IDLE, cnt=0, pulse_q=0, interval=0, interval_valid=0, timeout=0, early=0, busy=0. Reset overrides every other input, including mid-measurement.
- Edge detect: pulse_q <= pulse_in every cycle in every state. edge = pulse_in & ~pulse_q. A line already high when arm rises is not an edge.
- interval_valid and early default to 0 each cycle. They are single-cycle pulses.
- IDLE:
  - busy=0.
  - arm=1 -> state WAIT, cnt<=0, timeout<=0.
  - Edges are ignored.
- WAIT:
  - busy=1. Let E0 be the posedge that captured arm.
  - At posedge Ek, k>=1: if edge, then interval<=k (i.e. cnt+1), interval_valid<=1, cnt<=0, stay in WAIT. Measurement restarts from this edge.
  - Else if cnt==TIMEOUT-1: timeout<=1, state TIMEOUT, cnt<=0. Timeout is visible after posedge E_TIMEOUT.
  - Else: cnt<=cnt+1.
  - An edge coinciding with cnt==TIMEOUT-1 counts as in-time: interval=TIMEOUT, no timeout.
- TIMEOUT:
  - busy=0, timeout held at 1.
  - Edges are ignored; interval keeps its last value.
  - Leaving requires arm low (-> IDLE), then arm high again.
- arm=0 in any state -> IDLE next posedge. Any in-progress count is discarded; timeout is cleared; interval keeps its last value.
- Back-to-back edges are impossible, since edges are at least 2 cycles apart. The minimum measurable interval after a previous edge is therefore 2. From arm, the minimum is 1.
- Counter never exceeds TIMEOUT-1, so there is no wrap-around.

Optional Feature:
- Macro: PULSE_WATCHDOG_EARLY_EN.
- Defined: in the same cycle that interval_valid asserts, early<=1 if the new interval < MIN_INTERVAL. It is a strobe only; state and interval are unaffected.
- Undefined: early is tied to 0, MIN_INTERVAL is unused, and no compare logic is instantiated.

Test Plan:
All scenarios use BUS_WIDTH=8, TIMEOUT=10, MIN_INTERVAL=4.
- Reset and arm: rst 2 cycles, then arm=1 at E0, pulse_in=0 -> busy=1 from E0. timeout=1 after E10, busy=0.
- Single measurement: arm at E0, pulse_in rises sampled at E6 -> interval=6, interval_valid high one cycle after E6, timeout stays 0.
- Periodic heartbeat: edges every 7 cycles for 5 periods -> five interval_valid strobes, each with interval=7, no timeout.
- Boundary: edge sampled exactly at E10 -> interval=10, no timeout. Edge at E11 with none before -> timeout already 1 and edge ignored.
- Rearm and reset mid-operation: after timeout, drop arm 1 cycle then raise -> timeout=0, fresh count. rst asserted at cnt=5 -> all outputs 0 next cycle, including interval.
- Early (macro defined): edges 3 cycles apart -> interval=3, early strobe coincident with interval_valid. Macro undefined -> early stays 0.
